// File: rtl/fft_frame_scheduler.sv
// fft_frame_scheduler: captures a streamed frame, hands it to an FFT engine,
// then streams the engine's result bins out under valid/ready backpressure.
module fft_frame_scheduler #(
    parameter int WIDTH   = 32,
    parameter int SAMPLES = 16,
    parameter int TIMEOUT = 256
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [WIDTH-1:0]              sample_in,
    input  logic                          sample_valid,
    output logic                          sample_ready,
    output logic [SAMPLES-1:0][WIDTH-1:0] fft_samples,
    output logic                          fft_start,
    input  logic [SAMPLES-1:0][WIDTH-1:0] fft_result,
    input  logic                          fft_done,
    output logic [WIDTH-1:0]              bin_out,
    output logic [$clog2(SAMPLES)-1:0]    bin_idx,
    output logic                          bin_valid,
    input  logic                          bin_ready,
    output logic                          bin_last,
    output logic                          err_timeout,
    input  logic                          err_clr,
    output logic [15:0]                   frames_done
);
    localparam int IW = $clog2(SAMPLES);
    localparam int CW = IW + 1;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CAP_FULL = CW'(SAMPLES);
    localparam logic [IW-1:0] PTR_LAST = IW'(SAMPLES - 1);
    localparam logic [TW-1:0] WAIT_MAX = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {E_IDLE, E_START, E_BUSY, E_DRAIN} state_t;

    state_t                        r_state;
    logic [1:0]                    r_rst_sync;
    logic [CW-1:0]                 r_cap_cnt;
    logic [SAMPLES-1:0][WIDTH-1:0] r_cap;
    logic [SAMPLES-1:0][WIDTH-1:0] r_res;
    logic [IW-1:0]                 r_ptr;
    logic [TW-1:0]                 r_wait;
    logic                          w_rst_n;
    logic                          w_cap_fire;
    logic                          w_bin_fire;
    logic                          w_timeout;
    logic                          w_handoff;

    // Assertion is immediate; release reaches the logic two edges later
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_rst_sync <= 2'b00;
        else      r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
    assign w_rst_n = r_rst_sync[1];

    assign sample_ready = (r_cap_cnt < CAP_FULL);
    assign w_cap_fire   = sample_valid && sample_ready;
    assign w_handoff    = (r_state == E_IDLE) && (r_cap_cnt == CAP_FULL);
    assign bin_valid    = (r_state == E_DRAIN);
    assign bin_idx      = r_ptr;
    assign bin_out      = bin_valid ? r_res[r_ptr] : '0;
    assign bin_last     = bin_valid && (r_ptr == PTR_LAST);
    assign w_bin_fire   = bin_valid && bin_ready;
    assign w_timeout    = (r_state == E_BUSY) && !fft_done
                          && (r_wait == WAIT_MAX);

    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_cap_cnt <= '0;
            r_cap     <= '0;
        end else if (w_handoff) begin
            r_cap_cnt <= '0;
        end else if (w_cap_fire) begin
            r_cap[r_cap_cnt[IW-1:0]] <= sample_in;
            r_cap_cnt                <= r_cap_cnt + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state     <= E_IDLE;
            fft_samples <= '0;
            fft_start   <= 1'b0;
            r_res       <= '0;
            r_ptr       <= '0;
            r_wait      <= '0;
            err_timeout <= 1'b0;
            frames_done <= '0;
        end else begin
            fft_start <= 1'b0;
            if (w_timeout)    err_timeout <= 1'b1;
            else if (err_clr) err_timeout <= 1'b0;
            unique case (r_state)
                E_IDLE: begin
                    if (w_handoff) begin
                        fft_samples <= r_cap;
                        r_state     <= E_START;
                    end
                end
                E_START: begin
                    fft_start <= 1'b1;
                    r_wait    <= '0;
                    r_state   <= E_BUSY;
                end
                E_BUSY: begin
                    if (fft_done) begin
                        r_res   <= fft_result;
                        r_ptr   <= '0;
                        r_state <= E_DRAIN;
                    end else if (w_timeout) begin
                        r_state <= E_IDLE;
                    end else begin
                        r_wait <= r_wait + TW'(1);
                    end
                end
                E_DRAIN: begin
                    if (w_bin_fire) begin
                        r_ptr <= r_ptr + IW'(1);
                        if (bin_last) begin
                            r_state     <= E_IDLE;
                            frames_done <= frames_done + 16'd1;
                        end
                    end
                end
                default: r_state <= E_IDLE;
            endcase
        end
    end
endmodule
